// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and command opcodes.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

endpackage

// File: rtl/counter_sequencer_core.sv
// Counter datapath: synchronous clear (priority) and increment, async clear.
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] q
);

    // Counter register: clear beats increment, otherwise hold.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= {WIDTH{1'b0}};
        end else if (sync_clr) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: accepts START/PAUSE/RESUME/ABORT commands and drives
// the counter datapath up to a programmed limit in one-shot or periodic mode.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  limit_r;
    logic              periodic_r;
    logic              done_r;
    logic              err_r;
    logic              done_nxt_s;
    logic              err_nxt_s;
    logic              load_s;
    logic              en_s;
    logic              sync_clr_s;
    logic              accept_s;
    logic              terminal_s;
    logic [WIDTH-1:0]  count_s;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .clear_n  (clear_n),
        .en       (en_s),
        .sync_clr (sync_clr_s),
        .q        (count_s)
    );

    assign accept_s   = cmd_valid & cmd_ready;
    assign terminal_s = (count_s == limit_r);

    // Next-state, counter control and pulse decode for the current command.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        load_s      = 1'b0;
        en_s        = 1'b0;
        sync_clr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_START: begin
                            load_s      = 1'b1;
                            sync_clr_s  = 1'b1;
                            state_nxt_s = ST_RUN;
                        end
                        OP_ABORT: begin
                            sync_clr_s = 1'b1;
                        end
                        default: begin
                            err_nxt_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (cmd_op == OP_ABORT)) begin
                    sync_clr_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (terminal_s && !periodic_r) begin
                    // Any other command on the one-shot terminal edge is rejected.
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = accept_s;
                    state_nxt_s = ST_DONE;
                end else if (terminal_s) begin
                    done_nxt_s  = 1'b1;
                    sync_clr_s  = 1'b1;
                    err_nxt_s   = accept_s && ((cmd_op == OP_START) || (cmd_op == OP_RESUME));
                    state_nxt_s = (accept_s && (cmd_op == OP_PAUSE)) ? ST_PAUSE : ST_RUN;
                end else if (accept_s && (cmd_op == OP_PAUSE)) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    en_s      = 1'b1;
                    err_nxt_s = accept_s && ((cmd_op == OP_START) || (cmd_op == OP_RESUME));
                end
            end
            ST_PAUSE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_RESUME: state_nxt_s = ST_RUN;
                        OP_ABORT: begin
                            sync_clr_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                        default: err_nxt_s = 1'b1;
                    endcase
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, captured START parameters and one-cycle event pulses.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r    <= ST_IDLE;
            limit_r    <= {WIDTH{1'b0}};
            periodic_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            if (load_s) begin
                limit_r    <= cmd_limit;
                periodic_r <= cmd_periodic;
            end else begin
                limit_r    <= limit_r;
                periodic_r <= periodic_r;
            end
        end
    end

    assign cmd_ready = (state_r != ST_DONE);
    assign busy      = (state_r == ST_RUN) || (state_r == ST_PAUSE);
    assign count     = count_s;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control block that sequences a WIDTH-bit counter datapath for software/FSM clients. It accepts START/PAUSE/RESUME/ABORT commands over a valid/ready port and runs the counter from 0 up to a programmed limit, in one-shot or periodic mode. It flags terminal count with a one-cycle done pulse and flags illegal commands with an err pulse. It sits between the control plane and the counter datapath, replacing hand-driven clear/clock stimulus.

Parameters:
WIDTH, 4, counter and limit width in bits (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
clear_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at clk edge
cmd_op  input  2  00 START, 01 PAUSE, 10 RESUME, 11 ABORT
cmd_limit  input  WIDTH  terminal value, sampled on accepted START only
cmd_periodic  input  1  1 = periodic (wrap), 0 = one-shot; sampled on accepted START only
count  output  WIDTH  current counter value
busy  output  1  state is RUN or PAUSE
done  output  1  one-cycle pulse at terminal count
err  output  1  one-cycle pulse on an accepted illegal command

Behaviour:
- Clock/reset: one clock clk; reset clear_n is asynchronous, active-low.
- Reset (clear_n=0, async): state=IDLE, count=0, limit_q=0, periodic_q=0, done=0, err=0. Deassertion is taken synchronously in the next edge. Reset mid-RUN/PAUSE aborts immediately with no done pulse.
- States: IDLE, RUN, PAUSE, DONE. Encoding is held in the package.
- cmd_ready = (state != DONE). busy = (state==RUN | state==PAUSE). Both are combinational from state.
- done and err are registered and high for exactly one cycle per event.
- IDLE:
  - START: limit_q<=cmd_limit, periodic_q<=cmd_periodic, count<=0, ->RUN.
  - PAUSE or RESUME: err pulse, no state change.
  - ABORT: count<=0, stays IDLE, no err.
- RUN, evaluated each edge in priority order:
  - (1) ABORT: count<=0, ->IDLE, no done.
  - (2) Terminal (count==limit_q), one-shot: count holds at limit_q, done<=1, ->DONE. A simultaneous PAUSE is dropped and pulses err. A simultaneous START pulses err.
  - (3) Terminal, periodic: count<=0, done<=1. Next state is PAUSE if PAUSE was accepted this edge, else RUN.
  - (4) Non-terminal: PAUSE sets count hold and ->PAUSE. Otherwise count<=count+1.
  - START or RESUME in RUN: err pulse, counting continues.
- PAUSE:
  - count holds.
  - RESUME: ->RUN, increments resume the next edge.
  - ABORT: count<=0, ->IDLE.
  - START or PAUSE: err pulse.
- DONE: lasts exactly one cycle. cmd_ready=0, so no commands are accepted. count holds at limit_q, then ->IDLE. The count value remains visible in IDLE until the next START or ABORT.
- Latency (START accepted at edge N, limit L):
  - count=0 after edge N, and count=k after edge N+k.
  - done is high in the cycle following edge N+L+1.
  - One-shot: returns to IDLE after edge N+L+2.
  - Periodic: done every L+1 cycles while RUN, count sequence 0..L,0..L.
- Boundaries:
  - L=0, one-shot: done after edge N+1.
  - L=0, periodic: done every cycle, count stays 0.
  - L=2^WIDTH-1: count reaches all-ones, never overflows. Increment is modulo 2^WIDTH but is never reached past limit_q.
  - Pause cycles extend the period 1:1.
- Commands with cmd_valid=0 have no effect. cmd_limit and cmd_periodic are ignored except on an accepted START.

Decomposition:
- Package counter_seq_pkg: state enum (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE); op constants OP_START=2'b00, OP_PAUSE=2'b01, OP_RESUME=2'b10, OP_ABORT=2'b11.
- Sub-module counter_core (WIDTH): ports clk, clear_n, en, sync_clr, q. Synchronous increment when en, sync_clr has priority over en, async clear on clear_n. The sequencer FSM drives en/sync_clr and owns limit_q, periodic_q, done and err.

Test Plan:
- Reset: clear_n=0 for 2 cycles with random cmd inputs -> count=0, busy=0, done=0, err=0, cmd_ready=1. Release, 3 idle cycles -> outputs unchanged.
- One-shot: START L=5 periodic=0 at edge N -> count 0,1,2,3,4,5 on edges N..N+5. done=1 only in cycle after N+6. cmd_ready=0 in that cycle. IDLE after N+7 with count=5, busy=0.
- Periodic with pause: START L=3 periodic=1 -> count 0,1,2,3,0,1. done on each wrap. PAUSE at count=1 holds 1 for 4 cycles, busy=1. RESUME -> 2,3,0 with done at wrap.
- Illegal/priority: RESUME in IDLE -> err pulse, no state change. START in RUN -> err, counting continues. PAUSE on the one-shot terminal edge (L=2) -> done=1, err=1, state DONE. ABORT in RUN at count=3 -> count=0, IDLE, no done.
- Edge limits: L=0 one-shot -> done after edge N+1. L=0 periodic -> done=1 every cycle, count=0. L=15 (WIDTH=4) one-shot -> count reaches 4'b1111, done, no wrap.
- Async reset mid-RUN (count=2, L=9): clear_n low between edges -> count=0, busy=0 immediately, no done pulse after release.
